// File: rtl/tcb_img_packer_pkg.sv
// Shared definitions for the image packer.
// Holds the default parameter values, the output FSM state encoding and a
// small helper used to size the fill index.
package tcb_img_packer_pkg;

  localparam int N_PIX_DEF = 121;  // 11x11 image
  localparam int PIX_W_DEF = 8;
  localparam int RES_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Output stage states. Encoding is fixed so it can be read back from the
  // fsm_state debug port.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // output buffer free
    ST_OFFER    = 2'd1,  // image offered, valid_top high
    ST_WAIT_RES = 2'd2   // image taken, waiting for the classification
  } out_state_t;

  // Width of a counter that must hold 0..n-1; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tcb_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears the count
//   inc   - add one this cycle (ignored once the count is all ones)
//   count - current value, sticks at 2^CNT_W-1
module tcb_sat_counter
  import tcb_img_packer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tcb_img_packer.sv
// Image packer: collects a stream of pixels into a flat image, offers the
// image to a classification network and keeps hit/total statistics.
//
// Two buffers: the fill buffer receives the pixel stream while the output
// buffer holds the image (and its label) currently offered to or being
// processed by the network, so streaming of the next image overlaps the
// network's work on the previous one.
//
// Ports:
//   clk, rst             - clock (rising edge), async active-high reset
//   pix_in/pix_valid     - pixel stream in, pix_ready back-pressure out
//   label_in             - true class, sampled together with pixel 0
//   img_source/valid_top - flat image to the network, pixel 0 in the MSBs
//   ready_top            - network accepts the offered image
//   number/number_valid  - classification result strobe from the network
//   img_count/hit_count  - saturating statistics
//   fsm_state            - output FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1 (pix_valid/pix_ready for pixels, valid_top/ready_top for images).
// valid_top, once raised, stays high with img_source stable until the
// image is taken; number_valid is a single-cycle strobe with no ready and
// is only honoured while a result is awaited.
module tcb_img_packer
  import tcb_img_packer_pkg::*;
#(
  parameter int N_PIX = N_PIX_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [RES_W-1:0]       label_in,
  output logic [N_PIX*PIX_W-1:0] img_source,
  output logic                   valid_top,
  input  logic                   ready_top,
  input  logic [RES_W-1:0]       number,
  input  logic                   number_valid,
  output logic [CNT_W-1:0]       img_count,
  output logic [CNT_W-1:0]       hit_count,
  output out_state_t             fsm_state
);

  localparam int IDX_W = idx_width(N_PIX);
  localparam int IMG_W = N_PIX * PIX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

  logic [IMG_W-1:0] fill_buf;
  logic [IDX_W-1:0] fill_idx;
  logic             fill_full;
  logic [RES_W-1:0] fill_label;
  logic [RES_W-1:0] out_label;
  out_state_t       state;

  logic accept;
  logic transfer;
  logic res_done;
  logic res_hit;

  assign pix_ready = ~fill_full;
  assign accept    = pix_valid & pix_ready;
  // The fill buffer only moves into an idle output stage; a result arriving
  // on the same edge as the last pixel therefore delays the move by a cycle.
  assign transfer  = fill_full & (state == ST_IDLE);
  assign res_done  = (state == ST_WAIT_RES) & number_valid;
  assign res_hit   = res_done & (number == out_label);
  assign valid_top = (state == ST_OFFER);
  assign fsm_state = state;

  // Fill stage. accept and transfer never coincide: accept needs the
  // buffer not full, transfer needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_buf   <= '0;
      fill_idx   <= '0;
      fill_full  <= 1'b0;
      fill_label <= '0;
    end else if (accept) begin
      // Pixel k lands in slot N_PIX-1-k so pixel 0 ends up in the MSBs.
      for (int k = 0; k < N_PIX; k++) begin
        if (fill_idx == IDX_W'(k)) begin
          fill_buf[(N_PIX-1-k)*PIX_W +: PIX_W] <= pix_in;
        end
      end
      if (fill_idx == '0) begin
        fill_label <= label_in;
      end
      if (fill_idx == LAST_IDX) begin
        fill_idx  <= '0;
        fill_full <= 1'b1;
      end else begin
        fill_idx <= fill_idx + IDX_W'(1);
      end
    end else if (transfer) begin
      fill_full <= 1'b0;
    end
  end

  // Output stage: holds image and label from transfer until the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      img_source <= '0;
      out_label  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            img_source <= fill_buf;
            out_label  <= fill_label;
            state      <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (ready_top) begin
            state <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (number_valid) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tcb_sat_counter #(.CNT_W(CNT_W)) u_img_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (res_done),
    .count (img_count)
  );

  tcb_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (res_hit),
    .count (hit_count)
  );

endmodule

// File: tb/tb_tcb_img_packer.sv
`timescale 1ns/1ps
module tb_tcb_img_packer;
  import tcb_img_packer_pkg::*;

  localparam int N     = 121;
  localparam int PW    = 8;
  localparam int RW    = 8;
  localparam int CW    = 16;
  localparam int IMG_W = N * PW;
  localparam int N2    = 2;
  localparam int CW2   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT
  logic [PW-1:0]    pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [RW-1:0]    label_in = '0;
  logic [IMG_W-1:0] img_source;
  logic             valid_top;
  logic             ready_top = 1'b1;
  logic [RW-1:0]    number = '0;
  logic             number_valid = 1'b0;
  logic [CW-1:0]    img_count;
  logic [CW-1:0]    hit_count;
  out_state_t       fsm_state;

  tcb_img_packer #(.N_PIX(N), .PIX_W(PW), .RES_W(RW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .label_in(label_in),
    .img_source(img_source), .valid_top(valid_top), .ready_top(ready_top),
    .number(number), .number_valid(number_valid),
    .img_count(img_count), .hit_count(hit_count),
    .fsm_state(fsm_state)
  );

  // small DUT for counter saturation
  logic [PW-1:0]     b_pix_in = '0;
  logic              b_pix_valid = 1'b0;
  logic              b_pix_ready;
  logic [RW-1:0]     b_label_in = '0;
  logic [N2*PW-1:0]  b_img_source;
  logic              b_valid_top;
  logic              b_ready_top = 1'b1;
  logic [RW-1:0]     b_number = '0;
  logic              b_number_valid = 1'b0;
  logic [CW2-1:0]    b_img_count;
  logic [CW2-1:0]    b_hit_count;
  out_state_t        b_fsm_state;

  tcb_img_packer #(.N_PIX(N2), .PIX_W(PW), .RES_W(RW), .CNT_W(CW2)) u_dut_sat (
    .clk(clk), .rst(rst),
    .pix_in(b_pix_in), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
    .label_in(b_label_in),
    .img_source(b_img_source), .valid_top(b_valid_top), .ready_top(b_ready_top),
    .number(b_number), .number_valid(b_number_valid),
    .img_count(b_img_count), .hit_count(b_hit_count),
    .fsm_state(b_fsm_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [IMG_W-1:0] exp_q[$];
  int exp_img = 0;
  int exp_hit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [IMG_W-1:0] act,
                         input logic [IMG_W-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = -1;
      for (int k = 0; k < N; k++) begin
        if (bad < 0 && act[(N-1-k)*PW +: PW] !== exp[(N-1-k)*PW +: PW]) bad = k;
      end
      if (bad < 0) bad = 0;
      $display("FAIL %s: pixel %0d got %0h, expected %0h", name, bad,
               act[(N-1-bad)*PW +: PW], exp[(N-1-bad)*PW +: PW]);
    end
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_img_count"}, 32'(img_count), 32'(exp_img));
    chk({name, "_hit_count"}, 32'(hit_count), 32'(exp_hit));
  endtask

  function automatic logic [PW-1:0] pix_val(input logic [7:0] base, input logic [7:0] step,
                                             input int k);
    return base + step * 8'(k);
  endfunction

  function automatic logic [IMG_W-1:0] make_img(input logic [7:0] base, input logic [7:0] step);
    logic [IMG_W-1:0] img;
    img = '0;
    for (int k = 0; k < N; k++) img[(N-1-k)*PW +: PW] = pix_val(base, step, k);
    return img;
  endfunction

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic push_pix(input logic [PW-1:0] p, input logic [RW-1:0] l);
    int w;
    w = 0;
    pix_in = p;
    label_in = l;
    pix_valid = 1'b1;
    while (!pix_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!pix_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: pix_ready got 0, expected 1 within 300 cycles");
      pix_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      pix_valid = 1'b0;
    end
  endtask

  task automatic push_img(input logic [7:0] base, input logic [7:0] step, input logic [RW-1:0] l);
    exp_q.push_back(make_img(base, step));
    for (int k = 0; k < N; k++) push_pix(pix_val(base, step, k), l);
  endtask

  task automatic pop_check(input string name);
    logic [IMG_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: queue got empty, expected an image", name);
    end else begin
      e = exp_q.pop_front();
      chk_img(name, img_source, e);
    end
  endtask

  task automatic send_result(input logic [RW-1:0] n);
    number = n;
    number_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    number_valid = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] label;
    logic [7:0] num;
    int         exp_img;
    int         exp_hit;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [IMG_W-1:0] held;
    int w;

    tbl[0] = '{base: 8'h01, step: 8'h01, label: 8'd7,  num: 8'd7,  exp_img: 1, exp_hit: 1};
    tbl[1] = '{base: 8'hC0, step: 8'h01, label: 8'd5,  num: 8'd3,  exp_img: 2, exp_hit: 1};
    tbl[2] = '{base: 8'hFF, step: 8'hFF, label: 8'hAA, num: 8'hAA, exp_img: 3, exp_hit: 2};
    tbl[3] = '{base: 8'h80, step: 8'h03, label: 8'h00, num: 8'h01, exp_img: 4, exp_hit: 2};

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("rst_valid_top", 32'(valid_top), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    chk_img("rst_img_source", img_source, '0);
    chk_counts("rst");

    // result strobe while idle is ignored
    send_result(8'd0);
    @(negedge clk);
    chk_counts("idle_strobe");

    // table: full image, latency, handshake, result, counters
    for (int i = 0; i < 4; i++) begin
      push_img(tbl[i].base, tbl[i].step, tbl[i].label);
      chk("tbl_valid_before_xfer", 32'(valid_top), 32'd0);
      @(negedge clk);
      chk("tbl_valid_after_xfer", 32'(valid_top), 32'd1);
      pop_check("tbl_img");
      @(negedge clk);
      chk("tbl_wait_state", 32'(fsm_state), 32'(ST_WAIT_RES));
      chk("tbl_valid_taken", 32'(valid_top), 32'd0);
      send_result(tbl[i].num);
      exp_img = tbl[i].exp_img;
      exp_hit = tbl[i].exp_hit;
      chk_counts("tbl");
      chk("tbl_idle_state", 32'(fsm_state), 32'(ST_IDLE));
    end

    // back-pressure: image A held while image B fills, then stall
    ready_top = 1'b0;
    push_img(8'h10, 8'h02, 8'h11);
    @(negedge clk);
    chk("bp_valid_a", 32'(valid_top), 32'd1);
    held = make_img(8'h10, 8'h02);
    pop_check("bp_img_a");
    exp_q.push_back(make_img(8'h33, 8'h05));
    for (int k = 0; k < N; k++) begin
      push_pix(pix_val(8'h33, 8'h05, k), 8'h22);
      chk("bp_valid_hold", 32'(valid_top), 32'd1);
      chk_img("bp_img_stable", img_source, held);
    end
    chk("bp_pix_ready_full", 32'(pix_ready), 32'd0);
    pix_in = 8'hEE;
    pix_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", 32'(pix_ready), 32'd0);
    end
    pix_valid = 1'b0;
    ready_top = 1'b1;
    @(negedge clk);
    chk("bp_wait_state", 32'(fsm_state), 32'(ST_WAIT_RES));
    chk_img("bp_img_wait", img_source, held);
    send_result(8'h11);
    exp_img++;
    exp_hit++;
    chk_counts("bp_a");
    chk("bp_valid_gap", 32'(valid_top), 32'd0);
    @(negedge clk);
    chk("bp_valid_b", 32'(valid_top), 32'd1);
    pop_check("bp_img_b");
    chk("bp_pix_ready_free", 32'(pix_ready), 32'd1);
    @(negedge clk);
    send_result(8'h23);
    exp_img++;
    chk_counts("bp_b");

    // result and last pixel on the same edge: no bypass
    push_img(8'h05, 8'h07, 8'h44);
    @(negedge clk);
    pop_check("sim_img_c");
    @(negedge clk);
    chk("sim_wait_c", 32'(fsm_state), 32'(ST_WAIT_RES));
    exp_q.push_back(make_img(8'h60, 8'h01));
    for (int k = 0; k < N - 1; k++) push_pix(pix_val(8'h60, 8'h01, k), 8'h55);
    number = 8'h44;
    number_valid = 1'b1;
    push_pix(pix_val(8'h60, 8'h01, N - 1), 8'h55);
    number_valid = 1'b0;
    exp_img++;
    exp_hit++;
    chk("sim_state_idle", 32'(fsm_state), 32'(ST_IDLE));
    chk("sim_valid_low", 32'(valid_top), 32'd0);
    chk("sim_pix_ready", 32'(pix_ready), 32'd0);
    chk_counts("sim_c");
    @(negedge clk);
    chk("sim_valid_d", 32'(valid_top), 32'd1);
    pop_check("sim_img_d");
    @(negedge clk);
    send_result(8'h00);
    exp_img++;
    chk_counts("sim_d");

    // reset mid-image
    for (int k = 0; k < 60; k++) push_pix(8'hA0 + 8'(k), 8'h01);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(valid_top), 32'd0);
    chk("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    exp_img = 0;
    exp_hit = 0;
    chk_counts("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_pix_ready", 32'(pix_ready), 32'd1);
    push_img(8'h90, 8'h01, 8'd9);
    chk("post_rst_valid_pre", 32'(valid_top), 32'd0);
    @(negedge clk);
    chk("post_rst_valid", 32'(valid_top), 32'd1);
    pop_check("post_rst_img");
    @(negedge clk);
    chk("post_rst_wait", 32'(fsm_state), 32'(ST_WAIT_RES));

    // reset mid-handshake drops the outstanding result
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_img("hs_rst_img", img_source, '0);
    @(negedge clk);
    send_result(8'd9);
    chk_counts("hs_rst");
    chk("hs_rst_state", 32'(fsm_state), 32'(ST_IDLE));

    // saturation on the CNT_W=4 instance
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N2; k++) begin
        b_pix_in = 8'(k);
        b_label_in = 8'd3;
        b_pix_valid = 1'b1;
        w = 0;
        while (!b_pix_ready && w < 50) begin
          @(negedge clk);
          w++;
        end
        if (!b_pix_ready) begin
          checks++;
          errors++;
          $display("FAIL sat_push_timeout: pix_ready got 0, expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        b_pix_valid = 1'b0;
      end
      w = 0;
      while (b_fsm_state != ST_WAIT_RES && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (b_fsm_state != ST_WAIT_RES) begin
        checks++;
        errors++;
        $display("FAIL sat_wait_timeout: state got %0d, expected %0d", b_fsm_state, ST_WAIT_RES);
      end
      b_number = 8'd3;
      b_number_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_number_valid = 1'b0;
      if (i == 13) begin
        chk("sat_img_14", 32'(b_img_count), 32'd14);
        chk("sat_hit_14", 32'(b_hit_count), 32'd14);
      end
    end
    chk("sat_img_count", 32'(b_img_count), 32'd15);
    chk("sat_hit_count", 32'(b_hit_count), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time got 2000000 ns, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
